// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetch stage with a local instruction memory. The memory is filled through
// the loader port while idle. After start the unit fetches one word per cycle
// into a registered IF/ID output. It supports branch/jump redirects (one
// bubble) and has a sticky fault state that only rst clears.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous reset, active-high
//   start          leave IDLE and begin fetching
//   stall          hold the fetch stage and its outputs
//   redirect_en    branch/jump taken; reload pc from redirect_pc
//   redirect_pc    redirect target byte address
//   load_mem_en    memory write strobe (IDLE only)
//   load_mem_addr  word index to write
//   load_mem_data  word to write
//   instr          registered fetched instruction
//   pc_out         byte address of instr
//   instr_valid    instr/pc_out hold a real instruction
//   fault          sticky fetch fault
//   running        high while in RUN
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 32,
  parameter logic [31:0] RESET_PC = 32'h0,
  localparam int unsigned IDX_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic              redirect_en,
  input  logic [31:0]       redirect_pc,
  input  logic              load_mem_en,
  input  logic [IDX_W-1:0]  load_mem_addr,
  input  logic [DATA_W-1:0] load_mem_data,
  output logic [DATA_W-1:0] instr,
  output logic [31:0]       pc_out,
  output logic              instr_valid,
  output logic              fault,
  output logic              running
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [31:0]       pc_r;
  logic [31:0]       pc_nxt_s;
  logic [DATA_W-1:0] instr_nxt_s;
  logic [31:0]       pc_out_nxt_s;
  logic              valid_nxt_s;

  logic [DATA_W-1:0] mem_r [DEPTH];

  logic [IDX_W-1:0]  fetch_idx_s;
  logic              pc_oor_s;
  logic              redirect_misaligned_s;

  assign fetch_idx_s           = pc_r[IDX_W+1:2];
  // Any set bit above the memory's byte range means the pc left the image.
  assign pc_oor_s              = |pc_r[31:IDX_W+2];
  assign redirect_misaligned_s = |redirect_pc[1:0];

  // Instruction memory write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if ((state_r == ST_IDLE) && load_mem_en) begin
      mem_r[load_mem_addr] <= load_mem_data;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a pending load write takes precedence over start.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (load_mem_en) begin
          state_nxt_s = ST_IDLE;
        end else if (start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (redirect_en) begin
          if (redirect_misaligned_s) begin
            state_nxt_s = ST_FAULT;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else if (stall) begin
          state_nxt_s = ST_RUN;
        end else if (pc_oor_s) begin
          state_nxt_s = ST_FAULT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_FAULT: state_nxt_s = ST_FAULT;
      // An illegal encoding is treated as a fault so it cannot fetch.
      default:  state_nxt_s = ST_FAULT;
    endcase
  end

  // Next values for pc and the IF/ID register; everything holds unless RUN fetches.
  always_comb begin
    pc_nxt_s     = pc_r;
    instr_nxt_s  = instr;
    pc_out_nxt_s = pc_out;
    valid_nxt_s  = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (redirect_en) begin
          // Redirect wins over stall and inserts exactly one bubble.
          pc_nxt_s    = redirect_pc;
          valid_nxt_s = 1'b0;
        end else if (stall) begin
          valid_nxt_s = instr_valid;
        end else if (pc_oor_s) begin
          valid_nxt_s = 1'b0;
        end else begin
          instr_nxt_s  = mem_r[fetch_idx_s];
          pc_out_nxt_s = pc_r;
          valid_nxt_s  = 1'b1;
          pc_nxt_s     = pc_r + 32'd4;
        end
      end
      ST_IDLE:  valid_nxt_s = 1'b0;
      ST_FAULT: valid_nxt_s = 1'b0;
      default:  valid_nxt_s = 1'b0;
    endcase
  end

  // Datapath and status registers; fault/running follow the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r        <= RESET_PC;
      instr       <= '0;
      pc_out      <= 32'd0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
      running     <= 1'b0;
    end else begin
      pc_r        <= pc_nxt_s;
      instr       <= instr_nxt_s;
      pc_out      <= pc_out_nxt_s;
      instr_valid <= valid_nxt_s;
      fault       <= (state_nxt_s == ST_FAULT);
      running     <= (state_nxt_s == ST_RUN);
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Scoreboard bench. The driver issues one input vector per cycle on the
// falling edge. A reference model works out the visible outputs after the
// next rising edge and pushes them into a queue. The monitor pops one entry
// 1 ns after each rising edge and compares it against the DUT.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  localparam int DEPTH = 32;
  localparam int IDX_W = 5;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic        valid;
    logic        fault;
    logic        running;
  } obs_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             stall = 1'b0;
  logic             redirect_en = 1'b0;
  logic [31:0]      redirect_pc = 32'd0;
  logic             load_mem_en = 1'b0;
  logic [IDX_W-1:0] load_mem_addr = '0;
  logic [31:0]      load_mem_data = 32'd0;
  logic [31:0]      instr;
  logic [31:0]      pc_out;
  logic             instr_valid;
  logic             fault;
  logic             running;

  int vectors = 0;
  int miscompares = 0;

  obs_t exp_q[$];
  obs_t mon_exp;

  // Reference model state: the spec's three modes, plain integers.
  localparam int M_IDLE = 0;
  localparam int M_RUN = 1;
  localparam int M_FAULT = 2;
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc_out;
  logic        m_valid;
  logic [31:0] m_mem [DEPTH];

  instruction_fetch_unit #(
    .DATA_W  (32),
    .DEPTH   (DEPTH),
    .RESET_PC(32'h0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stall        (stall),
    .redirect_en  (redirect_en),
    .redirect_pc  (redirect_pc),
    .load_mem_en  (load_mem_en),
    .load_mem_addr(load_mem_addr),
    .load_mem_data(load_mem_data),
    .instr        (instr),
    .pc_out       (pc_out),
    .instr_valid  (instr_valid),
    .fault        (fault),
    .running      (running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input obs_t act, input obs_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got instr=%h pc_out=%h v=%b f=%b r=%b, want instr=%h pc_out=%h v=%b f=%b r=%b",
               nm, $time, act.instr, act.pc_out, act.valid, act.fault, act.running,
               exp.instr, exp.pc_out, exp.valid, exp.fault, exp.running);
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.instr   = m_instr;
    o.pc_out  = m_pc_out;
    o.valid   = m_valid;
    o.fault   = (m_mode == M_FAULT);
    o.running = (m_mode == M_RUN);
    return o;
  endfunction

  // Apply the spec's per-cycle rules to the model for one rising edge.
  task automatic model_step();
    if (m_mode == M_IDLE) begin
      m_valid = 1'b0;
      if (load_mem_en) m_mem[int'(load_mem_addr)] = load_mem_data;
      else if (start) m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (redirect_en) begin
        m_pc = redirect_pc;
        m_valid = 1'b0;
        if ((redirect_pc % 4) != 0) m_mode = M_FAULT;
      end else if (stall) begin
        // everything holds
      end else if (m_pc >= 32'(4 * DEPTH)) begin
        m_mode = M_FAULT;
        m_valid = 1'b0;
      end else begin
        m_instr = m_mem[int'(m_pc / 4)];
        m_pc_out = m_pc;
        m_valid = 1'b1;
        m_pc = m_pc + 32'd4;
      end
    end else begin
      m_valid = 1'b0;
    end
  endtask

  task automatic apply(input logic st, input logic stl, input logic rd,
                       input logic [31:0] rpc, input logic ld,
                       input logic [IDX_W-1:0] la, input logic [31:0] ldd);
    @(negedge clk);
    start = st; stall = stl; redirect_en = rd; redirect_pc = rpc;
    load_mem_en = ld; load_mem_addr = la; load_mem_data = ldd;
    model_step();
    exp_q.push_back(model_obs());
  endtask

  task automatic run_cycle();
    apply(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, '0, 32'd0);
  endtask

  // Asserts rst between clock edges and checks outputs drop immediately.
  task automatic do_reset();
    obs_t zero;
    zero = '0;
    @(posedge clk);
    #3;
    start = 1'b0; stall = 1'b0; redirect_en = 1'b0; redirect_pc = 32'd0;
    load_mem_en = 1'b0; load_mem_addr = '0; load_mem_data = 32'd0;
    rst = 1'b1;
    #1;
    chk("async_reset", {instr, pc_out, instr_valid, fault, running}, zero);
    m_mode = M_IDLE; m_pc = 32'h0; m_instr = 32'd0; m_pc_out = 32'd0; m_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: compare DUT outputs against the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      chk("vector", {instr, pc_out, instr_valid, fault, running}, mon_exp);
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [31:0] tgt;
    logic        rd;
    int          guard;

    do_reset();

    // Load phase: words 0..3 fixed, the rest random; start collides with a write once.
    for (int i = 0; i < DEPTH; i++) begin
      case (i)
        0: d = 32'h11;
        1: d = 32'h22;
        2: d = 32'h33;
        3: d = 32'h44;
        default: d = $urandom;
      endcase
      apply((i == 5) ? 1'b1 : 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, IDX_W'(i), d);
    end
    run_cycle();

    // Start, fetch 0 and 4, stall three cycles, then resume.
    apply(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, '0, 32'd0);
    run_cycle();
    run_cycle();
    repeat (3) apply(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, '0, 32'd0);
    run_cycle();
    run_cycle();

    // Redirect and stall together: one bubble, then the target.
    apply(1'b0, 1'b1, 1'b1, 32'h8, 1'b0, '0, 32'd0);
    run_cycle();

    // Loader guard: a write strobe in RUN must not alter memory.
    apply(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, '0, 32'hFF);
    apply(1'b0, 1'b0, 1'b1, 32'h0, 1'b0, '0, 32'd0);
    run_cycle();

    // Random phase with aligned in-range redirects, stalls and ignored loads.
    for (int i = 0; i < 150; i++) begin
      rd  = (($urandom % 10) == 0) || (m_pc >= 32'(4 * DEPTH - 8));
      tgt = {25'd0, 5'($urandom_range(0, DEPTH - 1)), 2'b00};
      apply(1'($urandom), (($urandom % 4) == 0), rd, tgt,
            1'($urandom), IDX_W'($urandom), $urandom);
    end

    // Sequential run-off past the last word.
    apply(1'b0, 1'b0, 1'b1, 32'(4 * DEPTH - 16), 1'b0, '0, 32'd0);
    guard = 0;
    while (m_mode != M_FAULT && guard < 20) begin
      run_cycle();
      guard++;
    end
    repeat (2) run_cycle();

    // Mid-run reset, then misaligned redirect and sticky fault.
    do_reset();
    apply(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, '0, 32'd0);
    repeat (3) run_cycle();
    do_reset();
    apply(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, '0, 32'd0);
    run_cycle();
    apply(1'b0, 1'b0, 1'b1, 32'h6, 1'b0, '0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 1'($urandom), 1'b1, 32'h10, 1'($urandom), IDX_W'($urandom), $urandom);
    end

    // Out-of-range redirect is accepted; the next real fetch faults.
    do_reset();
    apply(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, '0, 32'd0);
    run_cycle();
    apply(1'b0, 1'b0, 1'b1, 32'h400, 1'b0, '0, 32'd0);
    apply(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, '0, 32'd0);
    run_cycle();
    run_cycle();

    // Drain the scoreboard with a bounded wait.
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Parametrised instruction-fetch stage with an on-chip instruction memory, a loader port, a registered IF/ID output with a valid flag, branch/jump redirect with bubble insertion, and a sticky fetch-fault state. It feeds decode in the pipeline. It replaces the fixed 32-word, unregistered fetch stage with a configurable block that separates the load phase from the run phase.

## Interface
- DATA_W, 32, instruction width in bits
- DEPTH, 32, instruction memory depth in words; must be a power of two, ≥ 2
- RESET_PC, 32'h0, PC value loaded on reset; must be word-aligned
- IDX_W (local), $clog2(DEPTH), memory index width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous reset, active-high
- start  in  1  leave IDLE and begin fetching
- stall  in  1  hold the fetch stage and its outputs
- redirect_en  in  1  branch/jump taken; load the PC from redirect_pc
- redirect_pc  in  32  redirect target byte address
- load_mem_en  in  1  memory write strobe; honoured only in IDLE
- load_mem_addr  in  IDX_W  memory word index to write
- load_mem_data  in  DATA_W  word to write
- instr  out  DATA_W  registered fetched instruction
- pc_out  out  32  byte address of instr
- instr_valid  out  1  instr/pc_out hold a real instruction
- fault  out  1  sticky fetch fault
- running  out  1  high in RUN

## Operation
- Internal state: pc (32 bits), a DEPTH×DATA_W memory, and a state machine with states IDLE, RUN and FAULT.
- Memory contents are not reset. A fetch index is pc[IDX_W+1:2].
- **Reset.** pc=RESET_PC; instr=0; pc_out=0; instr_valid=0; fault=0; running=0; state=IDLE. Reset applies immediately, including in the middle of a run.
- **IDLE.**
  - load_mem_en=1 writes mem[load_mem_addr]<=load_mem_data. One word per cycle.
  - start=1 with load_mem_en=0 moves to RUN.
  - start and load_mem_en high in the same cycle: the write happens and start is ignored.
  - No fetch occurs in IDLE and instr_valid stays 0.
- **RUN.** Each cycle, the first matching rule applies:
  1. **redirect_en=1** (priority over stall):
     - pc<=redirect_pc; instr_valid<=0 (one bubble); instr and pc_out hold.
     - If redirect_pc[1:0]≠0, go to FAULT.
  2. **stall=1:** pc, instr, pc_out and instr_valid all hold.
  3. **Out-of-range pc** (pc[31:IDX_W+2]≠0): go to FAULT; instr_valid<=0.
  4. **Otherwise:** instr<=mem[pc index]; pc_out<=pc; instr_valid<=1; pc<=pc+4 (32-bit, wraps modulo 2^32).
  - load_mem_en is ignored in RUN; the memory is not modified.
- **FAULT.**
  - fault=1, instr_valid=0, running=0.
  - pc, instr and pc_out freeze.
  - All inputs are ignored. Only rst exits FAULT.
- **Sequential run-off.** After fetching pc=4·DEPTH−4, the next pc is 4·DEPTH. The following unstalled, unredirected cycle faults.
- **Out-of-range redirect target.** Accepted without error. The fault occurs on the next fetch attempt, not on the redirect itself.

## Timing
- Fetch latency is 1 cycle: pc sampled at edge N appears on instr/pc_out after edge N.
- The first valid instruction appears 1 cycle after the edge on which RUN is entered:
  - edge E: IDLE→RUN;
  - edge E+1: fetch of RESET_PC, so instr_valid=1 after E+1.
- Redirect at edge N:
  - instr_valid=0 after N;
  - the target instruction is valid after N+1, provided stall=0 at N+1.
- Fault is registered:
  - fault=1 after the edge on which the faulting condition is sampled;
  - instr_valid drops on that same edge.
- A memory write at edge N is visible to a fetch at edge N+1 or later. Writes are only possible before RUN, so there is no read/write hazard.
- running mirrors state==RUN and is a registered output.

## Test plan
- **Load and run.** DEPTH=32. Load words 0..3 = 0x11,0x22,0x33,0x44, then start. Required: after edges 1..4, (pc_out,instr) = (0,0x11),(4,0x22),(8,0x33),(12,0x44), with instr_valid=1 throughout.
- **Stall.** stall=1 for 3 cycles after pc_out=4 is shown. Required: instr=0x22 and pc_out=4 hold; the next value is (8,0x33) with no skip or duplicate.
- **Redirect plus stall together.** redirect_en=1, redirect_pc=0x8, stall=1 in the same cycle. Required: instr_valid=0 for one cycle, then (8,0x33).
- **Misaligned redirect.** redirect_pc=0x6. Required: fault=1 and instr_valid=0 one cycle later, fault sticky; start/redirect are ignored until rst.
- **Run-off.** DEPTH=4, run sequentially. Required: pc_out reaches 12; on the next cycle fault=1, instr_valid=0 and pc_out stays 12.
- **Reset and loader guard.**
  - Assert rst mid-RUN. Required: all outputs drop to reset values asynchronously and the state returns to IDLE.
  - In RUN, pulse load_mem_en with data 0xFF. Required: the memory is unchanged.
